// File: rtl/kw_pipe_sink.sv
// Credit-based receive FIFO at the tail of a fixed-latency, non-stallable pipeline.
// Credits cover both buffered and in-flight results, so a legally issued result always has a slot.
module kw_pipe_sink #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue,
    output logic                  issue_ok,
    input  logic                  pipe_valid,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      credits,
    output logic                  issue_err,
    output logic                  ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      occupancy;
    logic [CNT_W-1:0]      in_flight;
    logic [CNT_W-1:0]      credits_q;

    logic [CNT_W-1:0]      occ_next;
    logic [CNT_W-1:0]      in_flight_next;
    logic [CNT_W-1:0]      credits_next;
    logic [CNT_W:0]        used_next;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  issue_acc;
    logic                  stray;
    logic                  ovf_event;
    logic                  issue_event;

    assign out_valid = (occupancy != '0);
    assign out_data  = mem[rd_ptr];
    assign issue_ok  = (credits_q != '0);
    assign credits   = credits_q;

    always_comb begin
        full        = (occupancy == DEPTH_C);
        pop         = out_valid && out_ready;
        push        = pipe_valid && (!full || pop);
        issue_acc   = issue && issue_ok;
        // A result with nothing outstanding is a stray from an uncounted (illegal) issue.
        stray       = pipe_valid && (in_flight == '0);
        ovf_event   = (pipe_valid && full && !pop) || stray;
        issue_event = issue && !issue_ok;

        occ_next = occupancy;
        if (push && !pop) begin
            occ_next = occupancy + CNT_W'(1);
        end else if (pop && !push) begin
            occ_next = occupancy - CNT_W'(1);
        end

        in_flight_next = in_flight;
        if (issue_acc && !(pipe_valid && !stray)) begin
            in_flight_next = in_flight + CNT_W'(1);
        end else if (!issue_acc && pipe_valid && !stray) begin
            in_flight_next = in_flight - CNT_W'(1);
        end

        // Clamp keeps credits at zero rather than wrapping if accounting is ever exceeded.
        used_next = {1'b0, occ_next} + {1'b0, in_flight_next};
        if (used_next > {1'b0, DEPTH_C}) begin
            credits_next = '0;
        end else begin
            credits_next = DEPTH_C - used_next[CNT_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            in_flight <= '0;
            credits_q <= DEPTH_C;
            issue_err <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occupancy <= occ_next;
            in_flight <= in_flight_next;
            credits_q <= credits_next;
            if (issue_event) begin
                issue_err <= 1'b1;
            end
            if (ovf_event) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // Storage carries no reset; out_data is only meaningful while out_valid is high.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= pipe_data;
        end
    end

endmodule

// File: tb/tb_kw_pipe_sink.sv
// Directed bench for kw_pipe_sink: table-driven latency vectors plus hand sequences for fill,
// illegal issue, full-with-pop, backpressure and mid-burst reset.
module tb_kw_pipe_sink;

    localparam int DW = 16;
    localparam int DP = 8;
    localparam int CW = 4;

    logic          clock;
    logic          reset;
    logic          issue;
    logic          issue_ok;
    logic          pipe_valid;
    logic [DW-1:0] pipe_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] credits;
    logic          issue_err;
    logic          ovf_err;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic          issue;
        logic          pv;
        logic [DW-1:0] pd;
        logic          rdy;
        logic          e_ok;
        logic          e_ov;
        logic [DW-1:0] e_data;
        logic [CW-1:0] e_cr;
    } vec_t;

    vec_t vecs[5];

    kw_pipe_sink #(.DATA_WIDTH(DW), .DEPTH(DP), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .issue      (issue),
        .issue_ok   (issue_ok),
        .pipe_valid (pipe_valid),
        .pipe_data  (pipe_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .credits    (credits),
        .issue_err  (issue_err),
        .ovf_err    (ovf_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic i, input logic pv, input logic [DW-1:0] pd, input logic r);
        issue      = i;
        pipe_valid = pv;
        pipe_data  = pd;
        out_ready  = r;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pops the expected queue with out_ready held high, checking each head before it leaves.
    task automatic drain(input string name);
        int n;
        n = exp_q.size();
        drive(0, 0, '0, 1);
        for (int k = 0; k < n; k++) begin
            chk({name, "_valid"}, int'(out_valid), 1);
            chk({name, "_data"}, int'(out_data), int'(exp_q[0]));
            void'(exp_q.pop_front());
            tick();
        end
        chk({name, "_empty"}, int'(out_valid), 0);
    endtask

    // Credit invariant; only legal traffic is applied outside the illegal-issue window.
    always @(negedge clock) begin
        if (!reset) begin
            chk("invariant", int'(dut.occupancy) + int'(dut.in_flight) <= DP ? 1 : 0, 1);
        end
    end

    initial begin
        int delivered;
        logic pv;
        logic rdy;

        vecs[0] = '{issue: 1, pv: 0, pd: 16'h0000, rdy: 1, e_ok: 1, e_ov: 0, e_data: 16'h0000, e_cr: 4'd7};
        vecs[1] = '{issue: 0, pv: 0, pd: 16'h0000, rdy: 1, e_ok: 1, e_ov: 0, e_data: 16'h0000, e_cr: 4'd7};
        vecs[2] = '{issue: 0, pv: 0, pd: 16'h0000, rdy: 1, e_ok: 1, e_ov: 0, e_data: 16'h0000, e_cr: 4'd7};
        vecs[3] = '{issue: 0, pv: 1, pd: 16'h00A5, rdy: 1, e_ok: 1, e_ov: 1, e_data: 16'h00A5, e_cr: 4'd7};
        vecs[4] = '{issue: 0, pv: 0, pd: 16'h0000, rdy: 1, e_ok: 1, e_ov: 0, e_data: 16'h0000, e_cr: 4'd8};

        reset = 1'b1;
        drive(0, 0, '0, 0);
        tick();
        tick();
        chk("rst_issue_ok", int'(issue_ok), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_credits", int'(credits), DP);
        chk("rst_issue_err", int'(issue_err), 0);
        chk("rst_ovf_err", int'(ovf_err), 0);
        reset = 1'b0;

        // Basic latency: issue, result three cycles later, popped immediately.
        for (int v = 0; v < 5; v++) begin
            drive(vecs[v].issue, vecs[v].pv, vecs[v].pd, vecs[v].rdy);
            tick();
            chk($sformatf("vec%0d_issue_ok", v), int'(issue_ok), int'(vecs[v].e_ok));
            chk($sformatf("vec%0d_out_valid", v), int'(out_valid), int'(vecs[v].e_ov));
            chk($sformatf("vec%0d_credits", v), int'(credits), int'(vecs[v].e_cr));
            if (vecs[v].e_ov) begin
                chk($sformatf("vec%0d_out_data", v), int'(out_data), int'(vecs[v].e_data));
            end
        end

        // Fill to full; pointers start at 1 so the eight writes wrap.
        for (int k = 1; k <= DP; k++) begin
            drive(1, 0, '0, 0);
            tick();
            chk($sformatf("fill_issue_cr%0d", k), int'(credits), DP - k);
            chk($sformatf("fill_issue_ok%0d", k), int'(issue_ok), (k < DP) ? 1 : 0);
        end
        for (int k = 0; k < DP; k++) begin
            drive(0, 1, DW'(16'h0010 + k), 0);
            tick();
            chk($sformatf("fill_res_cr%0d", k), int'(credits), 0);
            chk($sformatf("fill_res_head%0d", k), int'(out_data), 16'h0010);
        end
        chk("fill_occ", int'(dut.occupancy), DP);
        chk("fill_ovf_err", int'(ovf_err), 0);
        chk("fill_issue_err", int'(issue_err), 0);

        // Illegal issue while out of credits.
        drive(1, 0, '0, 0);
        tick();
        chk("illegal_issue_err", int'(issue_err), 1);
        chk("illegal_in_flight", int'(dut.in_flight), 0);
        chk("illegal_credits", int'(credits), 0);
        chk("illegal_ovf_quiet", int'(ovf_err), 0);
        drive(0, 0, '0, 0);
        tick();
        chk("illegal_sticky", int'(issue_err), 1);
        drive(0, 1, 16'h00EE, 0);
        tick();
        chk("stray_ovf_err", int'(ovf_err), 1);
        chk("stray_occ", int'(dut.occupancy), DP);
        chk("stray_head", int'(out_data), 16'h0010);

        // Full with push and pop in the same cycle: word is accepted at the tail.
        drive(0, 1, 16'h0099, 1);
        tick();
        chk("simul_occ", int'(dut.occupancy), DP);
        chk("simul_head", int'(out_data), 16'h0011);
        chk("simul_credits", int'(credits), 0);
        for (int k = 1; k < DP; k++) exp_q.push_back(DW'(16'h0010 + k));
        exp_q.push_back(16'h0099);
        drain("wrap");
        chk("wrap_credits", int'(credits), DP);
        chk("wrap_issue_err_sticky", int'(issue_err), 1);
        chk("wrap_ovf_err_sticky", int'(ovf_err), 1);

        // Backpressure: six results while out_ready alternates 1,0,1,0.
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, '0, 0);
            tick();
        end
        chk("bp_credits_issued", int'(credits), 2);
        delivered = 0;
        for (int k = 0; k < 40; k++) begin
            pv  = (k < 6);
            rdy = ((k % 2) == 0);
            chk($sformatf("bp_valid%0d", k), int'(out_valid), (exp_q.size() != 0) ? 1 : 0);
            if (exp_q.size() != 0) begin
                chk($sformatf("bp_data%0d", k), int'(out_data), int'(exp_q[0]));
            end
            if (exp_q.size() != 0 && rdy) begin
                void'(exp_q.pop_front());
                delivered++;
            end
            if (pv) exp_q.push_back(DW'(16'h0020 + k));
            drive(0, pv, DW'(16'h0020 + k), rdy);
            tick();
            if (k >= 6 && exp_q.size() == 0) break;
        end
        drive(0, 0, '0, 0);
        chk("bp_delivered", delivered, 6);
        chk("bp_empty", int'(out_valid), 0);
        chk("bp_credits", int'(credits), DP);

        // Reset with five buffered and two in flight.
        for (int k = 0; k < 7; k++) begin
            drive(1, 0, '0, 0);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, DW'(16'h0030 + k), 0);
            tick();
        end
        drive(0, 0, '0, 0);
        chk("pre_rst_occ", int'(dut.occupancy), 5);
        chk("pre_rst_in_flight", int'(dut.in_flight), 2);
        chk("pre_rst_credits", int'(credits), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_credits", int'(credits), DP);
        chk("mid_rst_issue_ok", int'(issue_ok), 1);
        chk("mid_rst_issue_err", int'(issue_err), 0);
        chk("mid_rst_ovf_err", int'(ovf_err), 0);
        tick();
        chk("post_rst_credits", int'(credits), DP);
        chk("post_rst_out_valid", int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
